// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port Avalon-MM arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } port_t;

    localparam logic [3:0] FULL_BE = 4'hF;

endpackage

// File: rtl/avalon_mem_arbiter_rr_pick2.sv
// rtl/avalon_mem_arbiter_rr_pick2.sv - combinational two-way picker for fetch vs load/store
module rr_pick2
    import mem_arb_pkg::*;
#(
    parameter logic DATA_PRIORITY = 1'b1
) (
    input  logic  req_i,
    input  logic  req_d,
    input  port_t last_grant,
    output port_t grant
);

    // Lone requester wins; on a tie either data wins outright or the port that did not go last wins.
    always_comb begin
        grant = INST;
        if (req_d && !req_i) begin
            grant = DATA;
        end else if (req_d && req_i) begin
            if (DATA_PRIORITY) begin
                grant = DATA;
            end else if (last_grant == DATA) begin
                grant = INST;
            end else begin
                grant = DATA;
            end
        end
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - shares one Avalon-MM RAM port between fetch and load/store
module avalon_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        conflict
);

    arb_state_t state;
    arb_state_t state_nxt;
    port_t      owner;
    port_t      last_grant;
    port_t      pick;

    logic req_d;
    logic any_req;
    logic grant;
    logic complete;

    assign req_d    = d_read | d_write;
    assign any_req  = i_read | req_d;
    assign grant    = (state == IDLE) && any_req;
    assign complete = (state == XFER) && !waitrequest;

    rr_pick2 #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_pick (
        .req_i      (i_read),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one transaction at a time, DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = XFER;
            XFER:    if (!waitrequest) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request into the master outputs and hold it until RAM accepts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= INST;
            last_grant <= INST;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            conflict   <= 1'b0;
        end else if (grant) begin
            owner      <= pick;
            last_grant <= pick;
            if (pick == DATA) begin
                address    <= d_address;
                writedata  <= d_writedata;
                byteenable <= d_byteenable;
                write      <= d_write;
                read       <= !d_write;
                if (d_read && d_write) begin
                    conflict <= 1'b1;
                end
            end else begin
                address    <= i_address;
                byteenable <= FULL_BE;
                read       <= 1'b1;
                write      <= 1'b0;
            end
        end else if (complete) begin
            read  <= 1'b0;
            write <= 1'b0;
        end
    end

    // Report completion to the owner one cycle after RAM accepts, capturing read data on the way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_waitrequest <= 1'b1;
            d_waitrequest <= 1'b1;
            i_readdata    <= '0;
            d_readdata    <= '0;
        end else begin
            i_waitrequest <= 1'b1;
            d_waitrequest <= 1'b1;
            if (complete) begin
                if (owner == INST) begin
                    i_waitrequest <= 1'b0;
                    if (read) i_readdata <= readdata;
                end else begin
                    d_waitrequest <= 1'b0;
                    if (read) d_readdata <= readdata;
                end
            end
        end
    end

endmodule
